// File: rtl/pdm_ddr_tx_dual.sv
// Dual-channel PDM transmitter: two first-order sigma-delta modulators sharing one DDR data line.
// Define PDM_TX_UNDERRUN_MUTE_EN to load mid-scale on underrun instead of repeating the last pair.

module pdm_sd_chan #(
    parameter int PCM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic [PCM_W-1:0] sample,
    output logic             dbit
);
    logic [PCM_W-1:0] acc;
    logic [PCM_W-1:0] u;
    logic [PCM_W:0]   sum;

    // offset-binary view of the signed sample
    assign u    = {~sample[PCM_W-1], sample[PCM_W-2:0]};
    assign sum  = {1'b0, acc} + {1'b0, u};
    assign dbit = sum[PCM_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (step)
            acc <= sum[PCM_W-1:0];
    end
endmodule

module pdm_ddr_tx_dual #(
    parameter int CLK_DIV = 2,
    parameter int PCM_W   = 16,
    parameter int OSR     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PCM_W-1:0] pcm_in_0,
    input  logic [PCM_W-1:0] pcm_in_1,
    input  logic             pcm_valid,
    output logic             pcm_ready,
    output logic             pdm_clk,
    output logic             ddr_data,
    output logic             underrun
);
    localparam int NUM_CH = 2;
    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int FW = $clog2(OSR);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_MID    = DW'(CLK_DIV / 2 - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(OSR - 1);

    logic [DW-1:0] div_cnt;
    logic [FW-1:0] frame_cnt;
    logic [NUM_CH-1:0][PCM_W-1:0] act;
    logic [NUM_CH-1:0][PCM_W-1:0] hold;
    logic hold_full;

    logic tick_last, rise, frame_start, mid, accept, load;
    logic [NUM_CH-1:0] step;
    logic [NUM_CH-1:0] dbit;

    assign tick_last   = en && (div_cnt == DIV_LAST);
    assign rise        = tick_last && !pdm_clk;
    assign frame_start = rise && (frame_cnt == '0);
    assign mid         = en && (div_cnt == DIV_MID);
    // ch0 steps mid-low so its bit straddles the rising edge; ch1 mid-high
    assign step[0]     = mid && !pdm_clk;
    assign step[1]     = mid && pdm_clk;
    // accept and load are exclusive: load needs a full buffer, accept an empty one
    assign accept      = pcm_valid && !hold_full;
    assign load        = frame_start && hold_full;
    assign pcm_ready   = !hold_full;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        pdm_sd_chan #(.PCM_W(PCM_W)) u_chan (
            .clk    (clk),
            .rst    (rst),
            .step   (step[g]),
            .sample (act[g]),
            .dbit   (dbit[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            frame_cnt <= '0;
            pdm_clk   <= 1'b0;
            ddr_data  <= 1'b0;
        end else if (!en) begin
            div_cnt   <= '0;
            frame_cnt <= '0;
            pdm_clk   <= 1'b0;
            ddr_data  <= 1'b0;
        end else begin
            div_cnt <= tick_last ? '0 : div_cnt + 1'b1;
            if (tick_last)
                pdm_clk <= !pdm_clk;
            if (rise)
                frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
            if (mid)
                ddr_data <= pdm_clk ? dbit[1] : dbit[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
            act       <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= frame_start && !hold_full;
            if (accept) begin
                hold[0]   <= pcm_in_0;
                hold[1]   <= pcm_in_1;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            if (load)
                act <= hold;
`ifdef PDM_TX_UNDERRUN_MUTE_EN
            else if (frame_start)
                act <= '0;
`endif
        end
    end
endmodule

// File: tb/tb_pdm_ddr_tx_dual.sv
// Self-checking bench for pdm_ddr_tx_dual against a cycle-indexed arithmetic reference.
module tb_pdm_ddr_tx_dual;
    localparam int CD  = 2;
    localparam int W   = 16;
    localparam int OSR = 64;
    localparam int P   = 2 * CD;

    logic clk = 1'b0, rst = 1'b1, en = 1'b0, pcm_valid = 1'b0;
    logic [W-1:0] pcm_in_0 = '0, pcm_in_1 = '0;
    logic pcm_ready, pdm_clk, ddr_data, underrun;

    int total = 0, bad = 0;

    // reference state
    int n;
    longint acc[2];
    logic [W-1:0] act[2], hold[2];
    bit hfull, m_clk, m_ddr, m_und, accepted, ch0_step;
    bit counting = 0;
    int ones = 0;

    pdm_ddr_tx_dual #(.CLK_DIV(CD), .PCM_W(W), .OSR(OSR)) dut (
        .clk(clk), .rst(rst), .en(en),
        .pcm_in_0(pcm_in_0), .pcm_in_1(pcm_in_1), .pcm_valid(pcm_valid),
        .pcm_ready(pcm_ready), .pdm_clk(pdm_clk), .ddr_data(ddr_data), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        n = 0; hfull = 0; m_clk = 0; m_ddr = 0; m_und = 0;
        for (int c = 0; c < 2; c++) begin acc[c] = 0; act[c] = '0; hold[c] = '0; end
    endtask

    // running sum of offset values; each overflow past 2^W emits a one
    function automatic bit chan_step(input int c);
        longint u;
        u = longint'($signed(act[c])) + (longint'(1) << (W - 1));
        acc[c] += u;
        if (acc[c] >= (longint'(1) << W)) begin
            acc[c] -= (longint'(1) << W);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_edge();
        bit was_full, did_load;
        int pos, ph;
        was_full = hfull; did_load = 0; accepted = 0; ch0_step = 0; m_und = 0;
        if (en) begin
            pos = n % CD;
            ph  = (n / CD) % 2;
            if (pos == CD / 2 - 1) begin
                m_ddr = chan_step(ph);
                ch0_step = (ph == 0);
            end
            if (pos == CD - 1 && ph == 0 && (n / P) % OSR == 0) begin
                if (was_full) begin
                    act[0] = hold[0]; act[1] = hold[1]; did_load = 1;
                end else begin
                    m_und = 1;
`ifdef PDM_TX_UNDERRUN_MUTE_EN
                    act[0] = '0; act[1] = '0;
`endif
                end
            end
            m_clk = ((n + 1) / CD) % 2;
            n++;
        end else begin
            n = 0; m_clk = 0; m_ddr = 0;
        end
        if (pcm_valid && !was_full) begin
            hold[0] = pcm_in_0; hold[1] = pcm_in_1; hfull = 1; accepted = 1;
        end else if (did_load) begin
            hfull = 0;
        end
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ".pdm_clk"},   pdm_clk,   m_clk);
        chk({ctx, ".ddr_data"},  ddr_data,  m_ddr);
        chk({ctx, ".underrun"},  underrun,  m_und);
        chk({ctx, ".pcm_ready"}, pcm_ready, !hfull);
    endtask

    task automatic cyc(input string ctx);
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        #1;
        if (counting && ch0_step) ones += int'(ddr_data);
        check_outputs(ctx);
    endtask

    // mode 0: inputs untouched; 1: fresh random pair after each accept; 2: drop valid after accept
    task automatic run(input string ctx, input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) begin
            cyc(ctx);
            if (accepted && mode == 1) begin
                pcm_in_0 = W'($urandom); pcm_in_1 = W'($urandom);
            end else if (accepted && mode == 2) begin
                pcm_valid = 1'b0;
            end
        end
    endtask

    // asynchronous reset asserted between clock edges, checked before the next edge
    task automatic do_reset(input string ctx);
        #2 rst = 1'b1; en = 1'b0; pcm_valid = 1'b0;
        model_reset();
        #1 check_outputs(ctx);
        cyc(ctx);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #1 check_outputs("reset0");
        cyc("reset0");
        cyc("reset0");
        rst = 1'b0;

        en = 1'b1;
        run("midscale", 300, 0);

        pcm_in_0 = W'($urandom); pcm_in_1 = W'($urandom); pcm_valid = 1'b1;
        run("random", 1300, 1);

        do_reset("reset_mid");
        pcm_in_0 = 16'h7FFF; pcm_in_1 = 16'h8000; pcm_valid = 1'b1; en = 1'b1;
        run("chansep", 600, 2);

        do_reset("reset_neg");
        pcm_in_0 = 16'h8000; pcm_in_1 = 16'h8000; pcm_valid = 1'b1; en = 1'b1;
        run("fullneg", 600, 2);

        do_reset("reset_und");
        pcm_in_0 = 16'h4000; pcm_in_1 = W'($urandom); pcm_valid = 1'b1; en = 1'b1;
        run("underrun_f0", 65 * P, 2);
        counting = 1; ones = 0;
        run("underrun_f1", 64 * P, 0);
        counting = 0;
`ifdef PDM_TX_UNDERRUN_MUTE_EN
        chk("underrun_density", ones, 32);
`else
        chk("underrun_density", ones, 48);
`endif

        do_reset("reset_en");
        pcm_in_0 = W'($urandom); pcm_in_1 = W'($urandom); pcm_valid = 1'b1; en = 1'b1;
        run("endrop_run", P * OSR + 10 * P + 1, 2);
        en = 1'b0;
        cyc("endrop_off");
        chk("endrop_pdm_clk_low", pdm_clk, 1'b0);
        chk("endrop_ddr_low", ddr_data, 1'b0);
        pcm_in_0 = W'($urandom); pcm_in_1 = W'($urandom); pcm_valid = 1'b1;
        run("endrop_idle", 5, 2);
        chk("endrop_accepted", pcm_ready, 1'b0);
        en = 1'b1;
        run("endrop_reen", 2 * P, 0);
        chk("endrop_consumed", pcm_ready, 1'b1);
        run("endrop_tail", P * OSR, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pdm_ddr_tx_dual.md
# pdm_ddr_tx_dual

Dual-channel PDM transmitter that drives one shared DDR data line plus its PDM bit clock, the drive-side counterpart of the dual-microphone DDR-to-SDR capture path. Each channel converts signed PCM samples to a 1-bit stream with a first-order sigma-delta modulator. Channel 0 is valid around rising `pdm_clk` edges and channel 1 around falling edges. Used as a microphone-pair emulator for loopback test and as a PDM source for downstream DAC/amplifier parts.

## Interface
- `CLK_DIV`, 2: `clk` cycles per `pdm_clk` half-period; even, ≥2.
- `PCM_W`, 16: PCM sample width, signed two's complement.
- `OSR`, 64: PDM periods per PCM sample (frame length); ≥2.

- `clk` in 1: system clock; the only clock. All logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: run enable.
- `pcm_in_0` in PCM_W: channel 0 sample.
- `pcm_in_1` in PCM_W: channel 1 sample.
- `pcm_valid` in 1: sample pair offered.
- `pcm_ready` out 1: holding buffer empty; a pair is accepted when `pcm_valid && pcm_ready`.
- `pdm_clk` out 1: PDM bit clock, registered.
- `ddr_data` out 1: shared PDM data line, registered.
- `underrun` out 1: one-cycle pulse when a frame starts with the holding buffer empty.

## Operation
- **Reset values:**
  - Outputs: `pdm_clk`=0, `ddr_data`=0, `pcm_ready`=1, `underrun`=0.
  - Internal: `div_cnt`=0, `frame_cnt`=0, both accumulators=0, both active samples=0 (signed), holding buffer empty.
- **Buffering:**
  - One holding register pair plus one active register pair.
  - An accepted pair is written to the holding register pair, and `pcm_ready` drops on the next cycle.
  - Acceptance works regardless of `en`.
- **Divider:**
  - While `en`=1, `div_cnt` increments every cycle.
  - At `div_cnt==CLK_DIV-1`, `div_cnt`←0 and `pdm_clk` toggles.
- **Frame load:**
  - Occurs on the cycle `pdm_clk` goes 0→1 with `frame_cnt==0`.
  - If the holding buffer is full: active←holding, the buffer empties, and `pcm_ready`=1 next cycle.
  - If the holding buffer is empty: active is retained and `underrun` pulses.
  - `frame_cnt` increments mod OSR on every 0→1 edge.
  - Simultaneous accept and load: the load sees the pre-write buffer state. The accepted pair lands in holding, and the underrun is still reported.
- **Modulator, per channel:**
  - u = {~pcm[PCM_W-1], pcm[PCM_W-2:0]} (offset binary).
  - sum = acc + u, PCM_W+1 bits; bit = sum[PCM_W]; acc ← sum[PCM_W-1:0].
  - Ones density is u/2^PCM_W. Signed 0 gives 0,1,0,1,…
  - Each channel steps exactly once per PDM period.
- **Data drive:**
  - On the cycle with `div_cnt==CLK_DIV/2-1` in the low phase, channel 0 steps and `ddr_data`←ch0 bit.
  - The same point in the high phase steps channel 1 and drives `ddr_data`←ch1 bit.
- **Disable:**
  - `en` 1→0 at any point: next cycle `pdm_clk`=0, `ddr_data`=0, `div_cnt`=0, `frame_cnt`=0.
  - Accumulators, active samples and the holding buffer keep their values.
  - On re-enable, the first 0→1 edge is a frame load.

## Timing
- PDM period = 2·CLK_DIV `clk` cycles. `pdm_clk` duty is 50%.
- `ddr_data` changes only at mid-phase, so it is stable for CLK_DIV/2 cycles before and after each `pdm_clk` edge.
  - Ch0 bit is stable across the rising edge; ch1 bit across the falling edge.
- Sample latency: a sample loaded at a rising edge drives ch1 at the following mid-high point (CLK_DIV/2 cycles later) and ch0 at the next mid-low point.
- Pair throughput: one per OSR·2·CLK_DIV cycles.
- `pcm_ready` rises 1 cycle after a load and falls 1 cycle after an accept.
- `underrun` is high for exactly 1 cycle, coincident with the 0→1 `pdm_clk` register update.

## Configuration
- `PDM_TX_UNDERRUN_MUTE_EN` defined: on underrun, both active samples are loaded with signed 0 (mid-scale, 50% density).
- `PDM_TX_UNDERRUN_MUTE_EN` undefined: on underrun, the previous active samples are repeated.
- `underrun` pulses in both builds.

## Test plan
- **Reset:** assert `rst` mid-run. All outputs and state take their reset values immediately, without waiting for a `clk` edge.
- **Mid-scale:** `en`=1 with no samples offered (CLK_DIV=2). `pdm_clk` period is 4 `clk` cycles. Ch0 and ch1 each emit 0,1,0,1…
- **Channel separation:** pair ch0=0x7FFF, ch1=0x8000.
  - After the first load, sampling `ddr_data` at every rising `pdm_clk` edge gives 1, except one 0 per 65536 periods.
  - Every falling-edge sample gives 0.
- **Full-scale negative:** both channels 0x8000 (PCM_W=16), applied after the accumulators have been cleared by reset. `ddr_data` stays constant 0 for a full frame.
- **Underrun:** load one pair, then offer nothing for OSR periods.
  - `underrun` pulses once at the next frame start.
  - Ch0 density of 0x4000: repeated sample gives ones density 0.75; with `PDM_TX_UNDERRUN_MUTE_EN` it gives 0.5.
- **Enable drop:** deassert `en` at period 10 of a frame.
  - Next cycle `pdm_clk`=0 and `ddr_data`=0.
  - On re-enable, a frame load occurs at the first rising `pdm_clk` edge.
  - A pair accepted while disabled is consumed by that load.
